// File: rtl/str_arb_pkg.sv
// Shared types and helpers for the byte-output round-robin arbiter.
// rr_next works on an 8-wide request vector so one function serves every legal NUM_REQ.
package str_arb_pkg;

   localparam int HOLD_MAX   = 15;
   localparam int MAX_REQ    = 8;
   localparam int HOLD_CNT_W = 4;

   typedef enum logic {
      ARB_IDLE,
      ARB_HOLD
   } arb_state_e;

   // First set bit of valid scanning upward from last+1, wrapping at n.
   function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                          input logic [2:0] last,
                                          input int n);
      logic [2:0] sel;
      logic       found;
      int         idx;
      sel   = 3'd0;
      found = 1'b0;
      for (int i = 1; i <= MAX_REQ; i++) begin
         idx = (int'(last) + i) % n;
         if (i <= n && !found && valid[idx[2:0]]) begin
            sel   = idx[2:0];
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/str_edge_reg_arbiter_picker.sv
// Combinational rotating-priority picker: chooses the first valid requester after last_grant.
module str_rr_picker
   import str_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LG_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [LG_W-1:0]    last_grant,
   output logic [LG_W-1:0]    sel,
   output logic               any_valid
);

   always_comb begin
      sel       = LG_W'(rr_next(MAX_REQ'(req_valid), 3'(last_grant), NUM_REQ));
      any_valid = |req_valid;
   end

endmodule

// File: rtl/str_edge_reg_arbiter.sv
// Round-robin arbiter sharing one registered output word; each grant is held
// for HOLD_CYCLES cycles followed by at least one idle cycle.
//
//   state    | meaning
//   ARB_IDLE | data_valid low, offering req_ready to the picked requester
//   ARB_HOLD | word on data_out held stable, hold_cnt counting down to 0
module str_edge_reg_arbiter
   import str_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int DATA_W      = 8,
   parameter  int HOLD_CYCLES = 2,
   localparam int GID_W       = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         data_out,
   output logic                      data_valid,
   output logic [GID_W-1:0]          grant_id,
   output logic                      busy
);

   arb_state_e             state_q, state_d;
   logic [HOLD_CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [GID_W-1:0]       last_grant_q, last_grant_d;
   logic [DATA_W-1:0]      data_out_q, data_out_d;
   logic [GID_W-1:0]       grant_id_q, grant_id_d;
   logic                   data_valid_q, data_valid_d;
   logic                   busy_q, busy_d;
   logic [GID_W-1:0]       sel;
   logic                   any_valid;

   str_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .LG_W    (GID_W)
   ) u_picker (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .sel        (sel),
      .any_valid  (any_valid)
   );

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      last_grant_d = last_grant_q;
      data_out_d   = data_out_q;
      grant_id_d   = grant_id_q;
      data_valid_d = data_valid_q;
      busy_d       = busy_q;
      req_ready    = '0;
      case (state_q)
         ARB_IDLE: begin
            if (any_valid) begin
               req_ready[sel] = 1'b1;
               if (req_valid[sel]) begin
                  state_d      = ARB_HOLD;
                  data_out_d   = req_data[int'(sel)*DATA_W +: DATA_W];
                  grant_id_d   = sel;
                  last_grant_d = sel;
                  data_valid_d = 1'b1;
                  busy_d       = 1'b1;
                  hold_cnt_d   = HOLD_CNT_W'(HOLD_CYCLES - 1);
               end
            end
         end
         ARB_HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d      = ARB_IDLE;
               data_valid_d = 1'b0;
               busy_d       = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Requester 0 gets first priority out of reset, so last_grant starts at the top index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         hold_cnt_q   <= '0;
         last_grant_q <= GID_W'(NUM_REQ - 1);
         data_out_q   <= '0;
         grant_id_q   <= '0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         last_grant_q <= last_grant_d;
         data_out_q   <= data_out_d;
         grant_id_q   <= grant_id_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign grant_id   = grant_id_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_str_edge_reg_arbiter.sv
// Bench for str_edge_reg_arbiter: a per-cycle vector table for handshake, wrap and
// reset corners, then round-robin traffic scored against a queue of expected grants.
module tb_str_edge_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0, req_valid1 = '0;
   logic [31:0] req_data = '0, req_data1 = '0;
   logic [3:0]  req_ready, req_ready1;
   logic [7:0]  data_out, data_out1;
   logic        data_valid, data_valid1;
   logic [1:0]  grant_id, grant_id1;
   logic        busy, busy1;

   int n_vec = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   str_edge_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .data_out(data_out), .data_valid(data_valid),
      .grant_id(grant_id), .busy(busy));

   str_edge_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_data(req_data1),
      .req_ready(req_ready1), .data_out(data_out1), .data_valid(data_valid1),
      .grant_id(grant_id1), .busy(busy1));

   typedef struct {
      logic        rst_n;
      logic [3:0]  vld;
      logic [31:0] dat;
      logic [3:0]  rdy;
      logic        dv;
      logic [7:0]  dout;
      logic [1:0]  gid;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic r, input logic [3:0] v, input logic [31:0] d,
                               input logic [3:0] rdy, input logic dv, input logic [7:0] dout,
                               input logic [1:0] gid);
      vec_t x;
      x.rst_n = r; x.vld = v; x.dat = d; x.rdy = rdy; x.dv = dv; x.dout = dout; x.gid = gid;
      vecs.push_back(x);
   endfunction

   assert property (@(posedge clk) disable iff (!rst_n) busy |-> (req_ready == 4'b0000));

   // Continuous watch: no ready during HOLD, data_out frozen while data_valid stays high.
   logic       prev_dv = 1'b0, prev_dv1 = 1'b0;
   logic [7:0] prev_do = '0, prev_do1 = '0;
   always begin
      @(negedge clk);
      #2;
      if (rst_n) begin
         if (busy) chk("ready_in_hold", req_ready, 4'b0000);
         if (busy1) chk("ready_in_hold_h1", req_ready1, 4'b0000);
         if (data_valid && prev_dv) chk("dout_stable", data_out, prev_do);
         if (data_valid1 && prev_dv1) chk("dout_stable_h1", data_out1, prev_do1);
      end
      prev_dv  = data_valid;  prev_do  = data_out;
      prev_dv1 = data_valid1; prev_do1 = data_out1;
   end

   task automatic run_rr(input bit use1, input int hold, input logic [3:0] vld,
                         input logic [31:0] dat, input int ncyc);
      int         last, id;
      logic [3:0] exp_rdy, cur_rdy;
      logic       pdv, cur_dv;
      sb_t        e;
      rst_n = 1'b0; req_valid = '0; req_valid1 = '0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      if (use1) begin req_valid1 = vld; req_data1 = dat; end
      else begin req_valid = vld; req_data = dat; end
      last = 3;
      pdv  = 1'b0;
      sb.delete();
      for (int k = 0; k < ncyc; k++) begin
         #1;
         exp_rdy = '0;
         if (k % (hold + 1) == 0) begin
            id = last;
            do id = (id + 1) % 4; while (!vld[id]);
            exp_rdy[id] = 1'b1;
            last = id;
            e.id = 2'(id);
            e.data = dat[id*8 +: 8];
            sb.push_back(e);
         end
         cur_rdy = use1 ? req_ready1 : req_ready;
         cur_dv  = use1 ? data_valid1 : data_valid;
         chk(use1 ? "rr_ready_h1" : "rr_ready", cur_rdy, exp_rdy);
         chk(use1 ? "rr_dvalid_h1" : "rr_dvalid", cur_dv, (k % (hold + 1)) != 0);
         if (cur_dv && !pdv) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk(use1 ? "rr_dout_h1" : "rr_dout", use1 ? data_out1 : data_out, e.data);
               chk(use1 ? "rr_gid_h1" : "rr_gid", use1 ? grant_id1 : grant_id, e.id);
            end
         end
         pdv = cur_dv;
         @(negedge clk);
      end
      chk("sb_leftover", sb.size(), 0);
      req_valid = '0; req_valid1 = '0;
   endtask

   initial begin
      //   rst  vld      data           rdy      dv  dout   gid
      add(0, 4'b0000, 32'h0,         4'b0000, 0, 8'h00, 0);
      add(1, 4'b0001, 32'h000000A5,  4'b0001, 0, 8'h00, 0);
      add(1, 4'b0000, 32'h0,         4'b0000, 1, 8'hA5, 0);
      add(1, 4'b0000, 32'h0,         4'b0000, 1, 8'hA5, 0);
      add(1, 4'b0000, 32'h0,         4'b0000, 0, 8'hA5, 0);
      add(1, 4'b0010, 32'h00002100,  4'b0010, 0, 8'hA5, 0);
      add(1, 4'b1010, 32'h33002200,  4'b0000, 1, 8'h21, 1);
      add(1, 4'b1010, 32'h33002200,  4'b0000, 1, 8'h21, 1);
      add(1, 4'b1010, 32'h33002200,  4'b1000, 0, 8'h21, 1);
      add(1, 4'b0010, 32'h00002200,  4'b0000, 1, 8'h33, 3);
      add(1, 4'b0010, 32'h00002200,  4'b0000, 1, 8'h33, 3);
      add(1, 4'b0010, 32'h00002200,  4'b0010, 0, 8'h33, 3);
      add(1, 4'b0000, 32'h0,         4'b0000, 1, 8'h22, 1);
      add(1, 4'b0000, 32'h0,         4'b0000, 1, 8'h22, 1);
      add(1, 4'b0000, 32'h0,         4'b0000, 0, 8'h22, 1);
      add(1, 4'b0100, 32'h005C0000,  4'b0100, 0, 8'h22, 1);
      add(1, 4'b0000, 32'h0,         4'b0000, 1, 8'h5C, 2);
      add(0, 4'b0000, 32'h0,         4'b0000, 0, 8'h00, 0);
      add(1, 4'b0111, 32'h00626160,  4'b0001, 0, 8'h00, 0);
      add(1, 4'b0110, 32'h00626100,  4'b0000, 1, 8'h60, 0);
      add(1, 4'b0110, 32'h00626100,  4'b0000, 1, 8'h60, 0);
      add(1, 4'b0110, 32'h00626100,  4'b0010, 0, 8'h60, 0);
      add(1, 4'b0100, 32'h00620000,  4'b0000, 1, 8'h61, 1);
      add(1, 4'b0000, 32'h0,         4'b0000, 1, 8'h61, 1);
      add(1, 4'b0000, 32'h0,         4'b0000, 0, 8'h61, 1);
      add(1, 4'b0000, 32'h0,         4'b0000, 0, 8'h61, 1);

      @(negedge clk);
      foreach (vecs[i]) begin
         rst_n     = vecs[i].rst_n;
         req_valid = vecs[i].vld;
         req_data  = vecs[i].dat;
         #1;
         chk($sformatf("v%0d_ready", i), req_ready, vecs[i].rdy);
         chk($sformatf("v%0d_dvalid", i), data_valid, vecs[i].dv);
         chk($sformatf("v%0d_busy", i), busy, vecs[i].dv);
         chk($sformatf("v%0d_dout", i), data_out, vecs[i].dout);
         chk($sformatf("v%0d_gid", i), grant_id, vecs[i].gid);
         @(negedge clk);
      end

      run_rr(1'b0, 2, 4'b1111, 32'h13121110, 14);
      run_rr(1'b1, 1, 4'b0011, 32'h00004140, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end

endmodule

// File: doc/str_edge_reg_arbiter.md
# str_edge_reg_arbiter

Round-robin arbiter and sequencer that shares a single registered byte output among several requesters. Each accepted word is captured into the output register and held stable for a programmable minimum number of cycles before another requester may be served. This gives cycle-level hold and minimum-pulse-width guarantees on `data_out` for downstream timing-checked sinks. It sits in front of the edge-timing register path in the str test designs.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `DATA_W`, default 8: data width.
- `HOLD_CYCLES`, default 2: cycles `data_out` is held valid per grant; legal range 1..15.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ: per-requester valid.
- `req_data`  in  NUM_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ: one-hot (or zero) accept.
- `data_out`  out  DATA_W: registered output word.
- `data_valid`  out  1: high while the current word is in its hold window.
- `grant_id`  out  $clog2(NUM_REQ): index of the last accepted requester.
- `busy`  out  1: high in HOLD state.

## Operation
- States: IDLE and HOLD.
- IDLE:
  - If any `req_valid` is high, select the first valid index scanning upward from `last_grant+1`, modulo NUM_REQ.
  - Drive `req_ready[sel]=1` combinationally in the same cycle.
  - Transfer occurs when valid and ready are both high. On the next edge: `data_out<=req_data[sel]`, `grant_id<=sel`, `last_grant<=sel`, `data_valid<=1`, `busy<=1`, `hold_cnt<=HOLD_CYCLES-1`, state goes to HOLD.
- HOLD:
  - `req_ready` is all zero.
  - If `hold_cnt==0`, return to IDLE and clear `data_valid` and `busy`. Otherwise decrement `hold_cnt`.
- `data_out` and `grant_id` keep their last values in IDLE. They never change while `data_valid` is high.
- Requester rules: `req_valid` stays high and `req_data` stays stable until accepted. Dropping `req_valid` before acceptance is legal; that request is simply never granted.
- `req_ready` depends only on state, `req_valid` and `last_grant`. It has no combinational path from `req_data`.
- Reset, any time including mid-HOLD, forces: state IDLE, `data_out=0`, `data_valid=0`, `grant_id=0`, `busy=0`, `hold_cnt=0`, `last_grant=NUM_REQ-1` (requester 0 has first priority).
- The first edge after reset release may already accept a request.

## Timing
- Accept-to-output latency: 1 cycle. `data_out` and `data_valid` update on the edge that closes the handshake cycle.
- `data_valid` is high for exactly HOLD_CYCLES consecutive cycles per grant.
- Minimum spacing between accepts is HOLD_CYCLES+1 cycles. Peak throughput is 1/(HOLD_CYCLES+1).
- `data_valid` is low for at least 1 cycle between grants. This guarantees a low pulse of at least 1 cycle, used by sink width checks.
- Fairness: a continuously valid requester is served within NUM_REQ grants. Maximum wait is NUM_REQ*(HOLD_CYCLES+1) cycles.
- `last_grant` wraps from NUM_REQ-1 to 0.
- A request that becomes valid in the same cycle the FSM enters IDLE is eligible in that cycle.

## Structure
- Package `str_arb_pkg`:
  - state enum `arb_state_e` {ARB_IDLE, ARB_HOLD}
  - function `rr_next` returning the rotated first-valid index
  - localparam for the maximum HOLD_CYCLES (15)
- Sub-module `str_rr_picker`: purely combinational. Inputs `req_valid` and `last_grant`; outputs `sel` and `any_valid`. Instantiated once.
- Top level contains the FSM, `hold_cnt` (4 bits), `last_grant`, and the output registers.

## Test plan
- Reset release with `req_valid=4'b0001`, `req_data[7:0]=8'hA5` → `req_ready=0001` in the first cycle. Next cycle `data_out=A5`, `grant_id=0`, `data_valid` high for 2 cycles, then low.
- All four requesters valid continuously, data 8'h10..8'h13 → grant order 0,1,2,3,0. Accepts spaced exactly 3 cycles apart.
- `req_valid=1010` with `last_grant=1` → requester 3 is granted. On the next IDLE cycle requester 1 is granted (wrap-around).
- Assert `rst_n=0` on the 2nd HOLD cycle after granting 8'h5C → `data_out=0`, `data_valid=0`, `busy=0` immediately. After release, requester 0 is granted first.
- Requester 2 holds valid during HOLD, then drops it before IDLE → no grant to 2. `req_ready` is never high during HOLD (assertion).
- HOLD_CYCLES=1, requesters 0 and 1 valid → accepts every 2 cycles, `data_valid` toggling 1,0,1,0. `data_out` is stable whenever `data_valid` is high (assertion).
